// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx: sends one byte as two timed nibbles on the 4-bit HD44780 bus
module lcd_nibble_tx #(
    parameter int T_SETUP  = 2,
    parameter int T_EPULSE = 12,
    parameter int T_HOLD   = 1,
    parameter int T_GAP    = 50,
    parameter int T_WAIT   = 2000,
    parameter int CNT_W    = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       wr_rs,
    input  logic       nib_only,
    output logic       busy,
    output logic       done,
    output logic [3:0] lcd_d,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       sf_ce0
);
    typedef enum logic [3:0] {IDLE, SU_HI, E_HI, HD_HI, GAP, SU_LO, E_LO, HD_LO, WAIT} state_t;

    localparam logic [CNT_W-1:0] L_SETUP  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] L_EPULSE = CNT_W'(T_EPULSE - 1);
    localparam logic [CNT_W-1:0] L_HOLD   = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] L_GAP    = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] L_WAIT   = CNT_W'(T_WAIT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lim;
    logic [3:0]       lo_q;
    logic             last;

    assign lcd_rw = 1'b0;
    assign sf_ce0 = 1'b1;
    assign last   = cnt == lim;

    // final counter value of the current timed state
    always_comb begin
        lim = (state == SU_HI || state == SU_LO) ? L_SETUP :
              (state == E_HI  || state == E_LO)  ? L_EPULSE :
              (state == HD_HI || state == HD_LO) ? L_HOLD :
              (state == GAP)                     ? L_GAP : L_WAIT;
    end

    // sequencer: all bus outputs change only on state transitions, so E never glitches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            lo_q   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            lcd_d  <= '0;
            lcd_e  <= 1'b0;
            lcd_rs <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (wr_en) begin
                    lo_q   <= wr_data[3:0];
                    lcd_d  <= nib_only ? wr_data[3:0] : wr_data[7:4];
                    lcd_rs <= wr_rs;
                    busy   <= 1'b1;
                    cnt    <= '0;
                    state  <= nib_only ? SU_LO : SU_HI;
                end
            end else if (!last) begin
                cnt  <= cnt + 1'b1;
                done <= state == WAIT && cnt + 1'b1 == L_WAIT;
            end else begin
                cnt <= '0;
                case (state)
                    SU_HI: begin
                        state <= E_HI;
                        lcd_e <= 1'b1;
                    end
                    E_HI: begin
                        state <= HD_HI;
                        lcd_e <= 1'b0;
                    end
                    HD_HI: state <= GAP;
                    GAP: begin
                        state <= SU_LO;
                        lcd_d <= lo_q;
                    end
                    SU_LO: begin
                        state <= E_LO;
                        lcd_e <= 1'b1;
                    end
                    E_LO: begin
                        state <= HD_LO;
                        lcd_e <= 1'b0;
                    end
                    HD_LO: begin
                        state <= WAIT;
                        done  <= T_WAIT == 1;
                    end
                    default: begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        lcd_d  <= '0;
                        lcd_rs <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lcd_nibble_tx.sv
// tb_lcd_nibble_tx: randomized self-checking bench against a phase-based reference model
module tb_lcd_nibble_tx;
    localparam int TS = 2, TE = 12, TH = 1, TG = 50, TW = 2000;

    logic       clk = 1'b0, reset = 1'b0, wr_en = 1'b0, wr_rs = 1'b0, nib_only = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       busy, done, lcd_e, lcd_rs, lcd_rw, sf_ce0;
    logic [3:0] lcd_d;

    int n_chk = 0, n_fail = 0;

    int         stab = 0, hold_left = 0;
    logic [4:0] prev_v = '0, held = '0;
    logic       prev_e = 1'b0;

    lcd_nibble_tx #(.T_SETUP(TS), .T_EPULSE(TE), .T_HOLD(TH), .T_GAP(TG), .T_WAIT(TW), .CNT_W(12)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_rs(wr_rs),
        .nib_only(nib_only), .busy(busy), .done(done), .lcd_d(lcd_d), .lcd_e(lcd_e),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .sf_ce0(sf_ce0)
    );

    always #5 clk = ~clk;

    // expected {sf_ce0, lcd_rw, busy, done, lcd_e, lcd_rs, lcd_d} at offset n after acceptance
    function automatic logic [9:0] exp_vec(input logic [7:0] b, input logic rs, input logic nib, input int n);
        int hi, tot, m;
        hi  = nib ? 0 : TS + TE + TH + TG;
        tot = hi + TS + TE + TH + TW;
        if (n >= tot) return 10'b10_0000_0000;
        m = (n < hi) ? n : n - hi;
        return {1'b1, 1'b0, 1'b1, n == tot - 1, m >= TS && m < TS + TE, rs, (n < hi) ? b[7:4] : b[3:0]};
    endfunction

    // setup/hold watcher on the bus, called once per sampled cycle
    task automatic sh_mon();
        logic [4:0] v;
        v = {lcd_rs, lcd_d};
        if (!reset) begin
            stab = 0; hold_left = 0; prev_e = 1'b0; prev_v = v;
            return;
        end
        stab = (v == prev_v) ? stab + 1 : 0;
        if (lcd_e && !prev_e) begin
            n_chk++;
            if (stab < TS) begin
                n_fail++;
                $display("FAIL setup: stable %0d cycles before E rise, need %0d", stab, TS);
            end
            held = v;
        end
        if (!lcd_e && prev_e) hold_left = TH;
        if (hold_left > 0) begin
            n_chk++;
            if (v !== held) begin
                n_fail++;
                $display("FAIL hold: bus %h after E fall, need %h", v, held);
            end
            hold_left--;
        end
        prev_e = lcd_e;
        prev_v = v;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        sh_mon();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
            wr_data = 8'($urandom);
            cyc();
        end
    endtask

    // one transfer from acceptance to the first idle cycle, compared cycle by cycle
    task automatic run_xfer(input logic [7:0] b, input logic rs, input logic nib, input logic keep,
                            output int rise0, output int rise1, output int nrise, output int done_at,
                            output logic [3:0] nib0, output logic [3:0] nib1);
        int L, mism, first;
        logic [9:0] got, exp, fgot, fexp;
        logic pe;
        L = (nib ? 0 : TS + TE + TH + TG) + TS + TE + TH + TW;
        mism = 0; first = -1; rise0 = -1; rise1 = -1; nrise = 0; done_at = -1;
        nib0 = 'x; nib1 = 'x; pe = 1'b0; fgot = '0; fexp = '0;
        @(negedge clk);
        wr_en = 1'b1; wr_data = b; wr_rs = rs; nib_only = nib;
        for (int n = 0; n <= L; n++) begin
            if (n > 0) begin
                @(negedge clk);
                wr_data = 8'($urandom);
                wr_rs = 1'($urandom);
                nib_only = 1'($urandom);
                wr_en = keep ? 1'b1 : (n < L ? 1'($urandom) : 1'b0);
            end
            cyc();
            got = {sf_ce0, lcd_rw, busy, done, lcd_e, lcd_rs, lcd_d};
            exp = exp_vec(b, rs, nib, n);
            if (got !== exp) begin
                if (mism == 0) begin first = n; fgot = got; fexp = exp; end
                mism++;
            end
            if (lcd_e && !pe) begin
                if (nrise == 0) begin rise0 = n; nib0 = lcd_d; end
                else begin rise1 = n; nib1 = lcd_d; end
                nrise++;
            end
            if (done && done_at < 0) done_at = n;
            pe = lcd_e;
        end
        n_chk++;
        if (mism != 0) begin
            n_fail++;
            $display("FAIL waveform byte %h: %0d bad cycles, first at %0d got %b need %b", b, mism, first, fgot, fexp);
        end
    endtask

    task automatic test_reset();
        int r0, ne;
        n_chk++;
        if ({lcd_e, lcd_d, busy, done, lcd_rs, lcd_rw, sf_ce0} !== 10'b0_0000_0000_1) begin
            n_fail++;
            $display("FAIL reset_hold: got %b need %b", {lcd_e, lcd_d, busy, done, lcd_rs, lcd_rw, sf_ce0}, 10'b1);
        end
        @(negedge clk);
        reset = 1'b1;
        idle(3);
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'hA5; wr_rs = 1'b1; nib_only = 1'b0;
        cyc();
        for (int i = 0; i < TS + 3; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
            cyc();
        end
        n_chk++;
        if (lcd_e !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre: lcd_e %b need 1", lcd_e);
        end
        #2;
        reset = 1'b0;
        #1;
        sh_mon();
        n_chk++;
        if ({lcd_e, lcd_d, busy, done, lcd_rs, lcd_rw, sf_ce0} !== 10'b0_0000_0000_1) begin
            n_fail++;
            $display("FAIL reset_mid: got %b need %b", {lcd_e, lcd_d, busy, done, lcd_rs, lcd_rw, sf_ce0}, 10'b1);
        end
        @(negedge clk);
        reset = 1'b1;
        ne = 0; r0 = 0;
        for (int i = 0; i < 100; i++) begin
            idle(1);
            ne += lcd_e;
            r0 += busy;
        end
        n_chk++;
        if (ne != 0 || r0 != 0) begin
            n_fail++;
            $display("FAIL reset_discard: e_cycles %0d busy_cycles %0d need 0 0", ne, r0);
        end
    endtask

    task automatic test_byte();
        int r0, r1, nr, da;
        logic [3:0] n0, n1;
        run_xfer(8'h28, 1'b0, 1'b0, 1'b0, r0, r1, nr, da, n0, n1);
        n_chk++;
        if (r0 != 2 || r1 != 67 || nr != 2) begin
            n_fail++;
            $display("FAIL byte_edges: rises %0d,%0d count %0d need 2,67 count 2", r0, r1, nr);
        end
        n_chk++;
        if (n0 !== 4'h2 || n1 !== 4'h8) begin
            n_fail++;
            $display("FAIL byte_nibbles: %h,%h need 2,8", n0, n1);
        end
        n_chk++;
        if (da != 2079) begin
            n_fail++;
            $display("FAIL byte_done: done offset %0d need 2079", da);
        end
    endtask

    task automatic test_data();
        int r0, r1, nr, da;
        logic [3:0] n0, n1;
        run_xfer(8'h41, 1'b1, 1'b0, 1'b0, r0, r1, nr, da, n0, n1);
        n_chk++;
        if (n0 !== 4'h4 || n1 !== 4'h1 || nr != 2) begin
            n_fail++;
            $display("FAIL data_nibbles: %h,%h count %0d need 4,1 count 2", n0, n1, nr);
        end
        n_chk++;
        if (lcd_rs !== 1'b0) begin
            n_fail++;
            $display("FAIL data_rs_idle: lcd_rs %b need 0", lcd_rs);
        end
    endtask

    task automatic test_init_nibble();
        int r0, r1, nr, da;
        logic [3:0] n0, n1;
        run_xfer(8'h03, 1'b0, 1'b1, 1'b0, r0, r1, nr, da, n0, n1);
        n_chk++;
        if (nr != 1 || n0 !== 4'h3 || r0 != 2) begin
            n_fail++;
            $display("FAIL init_pulse: count %0d nibble %h rise %0d need 1 3 2", nr, n0, r0);
        end
        n_chk++;
        if (da != 2014) begin
            n_fail++;
            $display("FAIL init_done: done offset %0d need 2014", da);
        end
    endtask

    task automatic test_back_to_back();
        int r0, r1, nr, da, nr2;
        logic [3:0] n0, n1;
        run_xfer(8'h5C, 1'b1, 1'b0, 1'b1, r0, r1, nr, da, n0, n1);
        run_xfer(8'h9E, 1'b0, 1'b0, 1'b0, r0, r1, nr2, da, n0, n1);
        n_chk++;
        if (nr != 2 || nr2 != 2 || n0 !== 4'h9 || n1 !== 4'hE) begin
            n_fail++;
            $display("FAIL b2b: pulses %0d,%0d second nibbles %h,%h need 2,2 9,E", nr, nr2, n0, n1);
        end
        idle(2);
    endtask

    task automatic test_random();
        int r0, r1, nr, da;
        logic [3:0] n0, n1;
        logic [7:0] b;
        logic rs, nb;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom); rs = 1'($urandom); nb = 1'($urandom);
            run_xfer(b, rs, nb, 1'b0, r0, r1, nr, da, n0, n1);
            n_chk++;
            if (nr != (nb ? 1 : 2) || (nb ? n0 !== b[3:0] : (n0 !== b[7:4] || n1 !== b[3:0]))) begin
                n_fail++;
                $display("FAIL rand_%0d: byte %h nib %b pulses %0d nibbles %h,%h", i, b, nb, nr, n0, n1);
            end
            idle(int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_byte();
        test_data();
        test_init_nibble();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
